approx_mul_share_ctrl: RTL and testbench
========================================

Name: approx_mul_share_ctrl

Overview:
- Time-shares one combinational 8x8 unsigned approximate multiplier core among N_REQ requesters.
- Requesters use a valid/ready handshake. Requests are granted round-robin, and operands are registered and driven to the core.
- The core's product is registered and returned on a single response channel, tagged with the requester ID and subject to backpressure.
- Sits between accelerator lanes and the approximate multiplier instance. The core is external and is connected through the mul_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester ID width; must be >= clog2(N_REQ).
- XW, 8, operand width (x and y).
- ZW, 16, product width; must equal 2*XW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_x  in  N_REQ*XW  flattened x operands; requester i occupies [i*XW +: XW].
- req_y  in  N_REQ*XW  flattened y operands; same layout as req_x.
- mul_x  out  XW  x operand to the multiplier core (registered).
- mul_y  out  XW  y operand to the multiplier core (registered).
- mul_z  in  ZW  combinational product returned by the core.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_z  out  ZW  product.
- rsp_id  out  ID_W  index of the requester that issued the operation.

Behaviour:
- Reset (async assert, sync release):
  - Both pipeline valid bits clear; rsp_valid=0.
  - rsp_z=0, rsp_id=0, mul_x=0, mul_y=0.
  - Round-robin pointer rr_ptr=0; req_ready=0.
- Pipeline stages:
  - S1 (operand register): s1_vld, mul_x, mul_y, s1_id.
  - S2 (result register): rsp_valid, rsp_z, rsp_id.
- Stall and advance conditions:
  - s2_free = !rsp_valid | rsp_ready.
  - s1_adv = s1_vld & s2_free.
  - s1_free = !s1_vld | s1_adv.
- Arbitration (combinational):
  - Grant goes to the first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[g]=1 only when s1_free and a grant exists; all other bits are 0.
  - req_ready must not depend on req_valid of other requesters beyond the arbitration itself.
- Accept: on req_valid[g] & req_ready[g], load mul_x/mul_y from requester g, set s1_id=g and s1_vld=1, and set rr_ptr=(g+1) mod N_REQ.
- Idle: with no accept, rr_ptr holds; s1_vld clears if s1_adv fires.
- Transfer: on s1_adv, rsp_z<=mul_z, rsp_id<=s1_id, rsp_valid<=1.
- Retire: on rsp_valid & rsp_ready with no s1_adv, rsp_valid<=0.
- Latency and throughput:
  - Accept-to-rsp_valid is 2 cycles.
  - Throughput is 1 operation per cycle with rsp_ready held high.
  - Responses are in strict accept order.
- Backpressure: with rsp_ready low, S2 holds, then S1 holds, then req_ready drops to 0. No operation is dropped or duplicated, and rsp_z/rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous events: accept and S1 advance in the same cycle is legal; S1 reloads with the new operands.
- Core contract: mul_z is sampled only on s1_adv. Operands are held stable in mul_x/mul_y for the whole S1 residency.
- Reset mid-operation: in-flight operations are discarded; no response is produced after reset release.

Optional Feature:
- Macro: APPROX_ERR_MONITOR_EN.
- When defined:
  - An internal exact product mul_x*mul_y is computed in S1 and registered alongside the result.
  - Extra outputs:
    - err_cnt (32b): saturating count of retired responses where approx != exact.
    - err_max (ZW): maximum |exact-approx| seen so far.
    - err_clr (in, 1): synchronous clear of both.
  - All three reset to 0.
- When undefined: these ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package approx_mul_share_pkg: default widths (XW=8, ZW=16), error-counter width (32), and a response struct/typedef {id, z}.
- One sub-module, rr_arbiter (N parameter): inputs req and ptr; outputs grant one-hot, grant index and any-grant flag.

Test Plan (bench ties mul_z to an exact-product stub unless stated):
- Single request: req 0, x=0x0F, y=0x11, rsp_ready=1 -> exactly 2 cycles later rsp_valid=1, rsp_z=0x00FF, rsp_id=0.
- Fairness: all 4 requesters hold valid continuously -> grants issue in order 0,1,2,3,0,...; each requester gets 1 grant per 4 accepts, with no gaps.
- Backpressure: requester 2 sends 5 operations (x=k, y=3, k=1..5); rsp_ready low for 4 cycles mid-stream -> responses 3,6,9,12,15 in order, none lost; req_ready=0 while both stages are full.
- Reset in flight: assert rst_n=0 with S1 and S2 both full -> all outputs are 0 immediately; after release there is no response until a new accept.
- Wrap and sparse requests: rr_ptr=3, only requester 1 valid -> requester 1 is granted; rr_ptr becomes 2.
- APPROX_ERR_MONITOR_EN: stub returns exact-0x40 when x=0xFF, y=0xFF -> err_cnt=1 and err_max=0x0040; err_clr drives both to 0.

Source files
------------

// File: rtl/approx_mul_share_pkg.sv
// Shared widths, the response record and helpers for the approximate multiplier sharing controller.
// Optional feature macro: APPROX_ERR_MONITOR_EN (error monitor; see approx_mul_share_ctrl).
package approx_mul_share_pkg;

  localparam int unsigned XW_DEF    = 8;
  localparam int unsigned ZW_DEF    = 16;
  localparam int unsigned ERR_CNT_W = 32;
  // Wide enough for an ID of up to 16 requesters.
  localparam int unsigned ID_MAX_W  = 4;

  // Result-stage payload: issuing requester and its product.
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [ZW_DEF-1:0]   z;
  } rsp_t;

  // Magnitude of the difference of two products.
  function automatic logic [ZW_DEF-1:0] abs_diff(input logic [ZW_DEF-1:0] a,
                                                 input logic [ZW_DEF-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/approx_mul_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap-around) wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [PW-1:0] idx;

  // Walk the requesters starting at ptr; the first one found is granted.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = ptr;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PW'((32'(ptr) + off) % N);
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/approx_mul_share_ctrl.sv
// Time-shares one external combinational approximate multiplier among N_REQ requesters.
// Two-stage pipeline: S1 holds the granted operands on mul_x/mul_y, S2 holds the tagged product.
// Optional feature macro: APPROX_ERR_MONITOR_EN adds err_clr/err_cnt/err_max, comparing the
// core product against an exact product of the same operands.
module approx_mul_share_ctrl
  import approx_mul_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned XW    = XW_DEF,
  parameter int unsigned ZW    = ZW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*XW-1:0]  req_x,
  input  logic [N_REQ*XW-1:0]  req_y,
  output logic [XW-1:0]        mul_x,
  output logic [XW-1:0]        mul_y,
  input  logic [ZW-1:0]        mul_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ZW-1:0]        rsp_z,
  output logic [ID_W-1:0]      rsp_id
`ifdef APPROX_ERR_MONITOR_EN
  ,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ZW-1:0]        err_max
`endif
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             s1_vld_q, s1_vld_d;
  logic [XW-1:0]    mul_x_q, mul_x_d;
  logic [XW-1:0]    mul_y_q, mul_y_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             rsp_vld_q, rsp_vld_d;
  rsp_t             rsp_q, rsp_d;

  logic [N_REQ-1:0] gnt_oh;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             s2_free;
  logic             s1_adv;
  logic             s1_free;
  logic             accept;
  logic [XW-1:0]    sel_x;
  logic [XW-1:0]    sel_y;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Pipeline flow control: S2 frees on retire, S1 frees when it moves into S2.
  assign s2_free   = !rsp_vld_q || rsp_ready;
  assign s1_adv    = s1_vld_q && s2_free;
  assign s1_free   = !s1_vld_q || s1_adv;
  assign req_ready = s1_free ? gnt_oh : '0;
  assign accept    = s1_free && gnt_any;

  // One-hot operand select from the granted requester.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_x = req_x[i*XW +: XW];
        sel_y = req_y[i*XW +: XW];
      end
    end
  end

  // S1 and pointer update: load on accept, otherwise empty when the entry moves on.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    s1_vld_d = s1_vld_q;
    mul_x_d  = mul_x_q;
    mul_y_d  = mul_y_q;
    s1_id_d  = s1_id_q;
    if (accept) begin
      s1_vld_d = 1'b1;
      mul_x_d  = sel_x;
      mul_y_d  = sel_y;
      s1_id_d  = ID_W'(gnt_idx);
      rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end
  end

  // S2 update: capture the core product on advance, drop valid on retire.
  always_comb begin
    rsp_vld_d = rsp_vld_q;
    rsp_d     = rsp_q;
    if (s1_adv) begin
      rsp_vld_d = 1'b1;
      rsp_d.z   = ZW_DEF'(mul_z);
      rsp_d.id  = ID_MAX_W'(s1_id_q);
    end else if (rsp_vld_q && rsp_ready) begin
      rsp_vld_d = 1'b0;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      s1_vld_q  <= 1'b0;
      mul_x_q   <= '0;
      mul_y_q   <= '0;
      s1_id_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      s1_vld_q  <= s1_vld_d;
      mul_x_q   <= mul_x_d;
      mul_y_q   <= mul_y_d;
      s1_id_q   <= s1_id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_q     <= rsp_d;
    end
  end

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_z     = ZW'(rsp_q.z);
  assign rsp_id    = ID_W'(rsp_q.id);

`ifdef APPROX_ERR_MONITOR_EN
  logic [ZW-1:0]        exact_s1;
  logic [ZW-1:0]        exact_q, exact_d;
  logic [ZW-1:0]        diff;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ZW-1:0]        err_max_q, err_max_d;

  assign exact_s1 = ZW'(mul_x_q) * ZW'(mul_y_q);
  assign diff     = ZW'(abs_diff(ZW_DEF'(rsp_q.z), ZW_DEF'(exact_q)));

  // Exact product travels with the approximate one; statistics update on retire.
  always_comb begin
    exact_d   = exact_q;
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    if (s1_adv) begin
      exact_d = exact_s1;
    end
    if (err_clr) begin
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (rsp_vld_q && rsp_ready) begin
      if ((diff != '0) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      if (diff > err_max_q) begin
        err_max_d = diff;
      end
    end
  end

  // Error monitor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_q   <= '0;
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else begin
      exact_q   <= exact_d;
      err_cnt_q <= err_cnt_d;
      err_max_q <= err_max_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_approx_mul_share_ctrl.sv
// Self-checking bench for approx_mul_share_ctrl with a stub multiplier core.
// Optional feature macro: APPROX_ERR_MONITOR_EN enables the error-monitor sequence.
`timescale 1ns/1ps
module tb_approx_mul_share_ctrl;
  import approx_mul_share_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int XW = 8;
  localparam int ZW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*XW-1:0] req_x = '0;
  logic [N*XW-1:0] req_y = '0;
  logic [XW-1:0]   mul_x;
  logic [XW-1:0]   mul_y;
  logic [ZW-1:0]   mul_z;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [ZW-1:0]   rsp_z;
  logic [IW-1:0]   rsp_id;
  logic            stub_err_en = 1'b0;
`ifdef APPROX_ERR_MONITOR_EN
  logic            err_clr = 1'b0;
  logic [31:0]     err_cnt;
  logic [ZW-1:0]   err_max;
`endif

  always #5 clk = ~clk;

  // Stub core: exact product, optionally 0x40 low for 0xFF*0xFF.
  function automatic logic [15:0] core_model(input logic [7:0] x, input logic [7:0] y,
                                             input logic err);
    logic [15:0] p;
    p = 16'(x) * 16'(y);
    if (err && x == 8'hFF && y == 8'hFF) p = p - 16'h0040;
    return p;
  endfunction

  assign mul_z = core_model(mul_x, mul_y, stub_err_en);

  approx_mul_share_ctrl #(.N_REQ(N), .ID_W(IW), .XW(XW), .ZW(ZW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_z     (mul_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id)
`ifdef APPROX_ERR_MONITOR_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
    .err_max   (err_max)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Scoreboard and logs.
  typedef struct {
    int          id;
    logic [15:0] z;
  } exp_t;

  exp_t        sb[$];
  int          gnt_log[$];
  int          gnt_cyc[$];
  logic [15:0] rsp_log[$];
  exp_t        e;
  int          cyc = 0;
  int          full_seen = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_z = '0;
  logic [1:0]  prev_id = '0;

  // Monitor: observes handshakes half a cycle before the edge that acts on them.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (prev_stall) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_z", 32'(rsp_z), 32'(prev_z));
        check("hold_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && !rsp_ready && sb.size() >= 2) begin
        full_seen++;
        check("both_full_ready", 32'(req_ready), 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id %0d z 0x%0h, required no response", rsp_id, rsp_z);
        end else begin
          e = sb.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e.id));
          check("sb_z", 32'(rsp_z), 32'(e.z));
          rsp_log.push_back(rsp_z);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = i;
          e.z  = core_model(req_x[i*XW +: XW], req_y[i*XW +: XW], stub_err_en);
          sb.push_back(e);
          gnt_log.push_back(i);
          gnt_cyc.push_back(cyc);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_z     = rsp_z;
      prev_id    = rsp_id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] x, input logic [7:0] y);
    req_valid[id]        = 1'b1;
    req_x[id*XW +: XW]   = x;
    req_y[id*XW +: XW]   = y;
  endtask

  task automatic wait_accept(input int id, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!(req_valid[id] && req_ready[id]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) fail_now(name);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail_now("drain");
    @(negedge clk);
  endtask

  typedef struct {
    int          id;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 8'h0F, 8'h11, 16'h00FF};
    vecs[1] = '{1, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{2, 8'h00, 8'hAB, 16'h0000};
    vecs[3] = '{3, 8'h80, 8'h02, 16'h0100};
    vecs[4] = '{1, 8'h01, 8'h01, 16'h0001};
    vecs[5] = '{3, 8'hFF, 8'h01, 16'h00FF};

    // Reset state.
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_z", 32'(rsp_z), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_mul_x", 32'(mul_x), 32'd0);
    check("rst_mul_y", 32'(mul_y), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();

    // Single requests: two-cycle latency and exact product.
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].id, vecs[v].x, vecs[v].y);
      wait_accept(vecs[v].id, "vec_accept");
      tick();
      req_valid = '0;
      @(negedge clk);
      check("vec_lat1_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("vec_lat2_valid", 32'(rsp_valid), 32'd1);
      check("vec_z", 32'(rsp_z), 32'(vecs[v].z));
      check("vec_id", 32'(rsp_id), 32'(vecs[v].id));
      tick();
    end

    // Fairness: all four hold valid; grants rotate with no gaps.
    gnt_log.delete();
    gnt_cyc.delete();
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 8'(8'h10 + i));
    begin
      int k;
      k = 0;
      while (gnt_log.size() < 16 && k < 100) begin
        @(posedge clk);
        k++;
      end
      #1;
      req_valid = '0;
      if (gnt_log.size() < 16) fail_now("fair_grants");
      else begin
        for (int j = 0; j < 16; j++) begin
          check("fair_order", 32'(gnt_log[j]), 32'(j % 4));
          check("fair_no_gap", 32'(gnt_cyc[j] - gnt_cyc[0]), 32'(j));
        end
      end
    end
    drain();

    // Backpressure: stream of five from requester 2 with a four-cycle stall.
    rsp_log.delete();
    full_seen = 0;
    tick();
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          set_req(2, 8'(k), 8'd3);
          wait_accept(2, "bp_accept");
          tick();
        end
        req_valid[2] = 1'b0;
      end
      begin
        tick();
        tick();
        rsp_ready = 1'b0;
        repeat (4) tick();
        rsp_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(rsp_log.size()), 32'd5);
    if (rsp_log.size() == 5) begin
      for (int k = 0; k < 5; k++) check("bp_value", 32'(rsp_log[k]), 32'(3 * (k + 1)));
    end
    check("bp_full_seen", 32'(full_seen > 0), 32'd1);

    // Reset with both stages occupied.
    tick();
    rsp_ready = 1'b0;
    set_req(1, 8'h12, 8'h34);
    wait_accept(1, "rst_accept1");
    tick();
    set_req(1, 8'h05, 8'h06);
    wait_accept(1, "rst_accept2");
    tick();
    set_req(1, 8'h77, 8'h01);
    @(negedge clk);
    check("rst_pre_valid", 32'(rsp_valid), 32'd1);
    check("rst_pre_ready", 32'(req_ready), 32'd0);
    check("rst_pre_mul_x", 32'(mul_x), 32'h05);
    #2;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_rsp_z", 32'(rsp_z), 32'd0);
    check("rst_mid_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_mid_mul_x", 32'(mul_x), 32'd0);
    check("rst_mid_mul_y", 32'(mul_y), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    tick();

    // Wrap: pointer at 3 with only requester 1 valid, then confirm pointer is 2.
    set_req(2, 8'h03, 8'h04);
    wait_accept(2, "wrap_setup");
    tick();
    req_valid = '0;
    set_req(1, 8'h07, 8'h09);
    @(negedge clk);
    check("wrap_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    set_req(1, 8'h02, 8'h02);
    set_req(2, 8'h04, 8'h04);
    set_req(3, 8'h06, 8'h06);
    @(negedge clk);
    check("wrap_ptr2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    drain();

`ifdef APPROX_ERR_MONITOR_EN
    // Error monitor: one erroneous product, one exact, then clear.
    tick();
    stub_err_en = 1'b1;
    set_req(0, 8'hFF, 8'hFF);
    wait_accept(0, "err_accept1");
    tick();
    req_valid = '0;
    drain();
    check("err_cnt_one", err_cnt, 32'd1);
    check("err_max_40", 32'(err_max), 32'h40);
    set_req(0, 8'h03, 8'h05);
    wait_accept(0, "err_accept2");
    tick();
    req_valid = '0;
    drain();
    check("err_cnt_hold", err_cnt, 32'd1);
    check("err_max_hold", 32'(err_max), 32'h40);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cnt_clr", err_cnt, 32'd0);
    check("err_max_clr", 32'(err_max), 32'd0);
    stub_err_en = 1'b0;
`endif

    tick();
    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
